// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (fetch / data) arbiter onto one shared memory port,
//            data-priority with a bounded run to keep fetches from starving.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MAX_DM_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam int             RUN_W   = $clog2(MAX_DM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_ACC = 2'd1;
    localparam logic [1:0] S_DM_ACC = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [RUN_W-1:0] dm_run;
    logic             sel_dm;
    logic             acc_we;
    logic             starving;
    logic             grant_dm;
    logic             grant_if;
    logic             in_access;

    // Data wins ties unless a waiting fetch has already sat out a full run.
    always_comb begin
        starving  = if_req && (dm_run == RUN_MAX);
        grant_dm  = (state == S_IDLE) && dm_req && !starving;
        grant_if  = (state == S_IDLE) && !grant_dm && if_req;
        in_access = (state == S_IF_ACC) || (state == S_DM_ACC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_dm)      state_nxt = S_DM_ACC;
                else if (grant_if) state_nxt = S_IF_ACC;
            end
            S_IF_ACC, S_DM_ACC: begin
                if (mem_ready) state_nxt = S_RESP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = in_access;
        mem_we = (state == S_DM_ACC) && acc_we;
        if_ack = (state == S_RESP) && !sel_dm;
        dm_ack = (state == S_RESP) && sel_dm;
        busy   = (state != S_IDLE);
    end

    // Access attributes are latched at grant so the memory sees a stable request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dm_run    <= '0;
            sel_dm    <= 1'b0;
            acc_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (grant_dm) begin
                sel_dm    <= 1'b1;
                acc_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                if (dm_run != RUN_MAX) dm_run <= dm_run + 1'b1;
            end else if (grant_if) begin
                sel_dm    <= 1'b0;
                acc_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                dm_run    <= '0;
            end
            if (in_access && mem_ready) begin
                if (state == S_IF_ACC) if_rdata <= mem_rdata;
                else if (!acc_we)      dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Vector table, directed corner sequences and randomized traffic
//            against a transaction-level reference model for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int MAX_RUN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_en, mem_we, busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.MAX_DM_RUN(MAX_RUN)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic ifr, input logic [31:0] ifa, input logic dmr,
                          input logic dwe, input logic [31:0] dma, input logic [31:0] dwd,
                          input logic rdy, input logic [31:0] rd);
        if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = dwe;
        dm_addr = dma; dm_wdata = dwd; mem_ready = rdy; mem_rdata = rd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ifr; logic [31:0] ifa; logic dmr; logic dwe; logic [31:0] dma;
        logic [31:0] dwd; logic rdy; logic [31:0] rd;
        logic en; logic we; logic [31:0] addr; logic [31:0] wdata;
        logic ifack; logic dmack; logic bsy; logic [31:0] ifrd; logic [31:0] dmrd;
    } vec_t;

    function automatic vec_t mk(input logic ifr, input logic [31:0] ifa, input logic dmr,
        input logic dwe, input logic [31:0] dma, input logic [31:0] dwd, input logic rdy,
        input logic [31:0] rd, input logic en, input logic we, input logic [31:0] addr,
        input logic [31:0] wdata, input logic ifack, input logic dmack, input logic bsy,
        input logic [31:0] ifrd, input logic [31:0] dmrd);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dwe = dwe; v.dma = dma; v.dwd = dwd;
        v.rdy = rdy; v.rd = rd; v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ifack = ifack; v.dmack = dmack; v.bsy = bsy; v.ifrd = ifrd; v.dmrd = dmrd;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // ph: 0 = nothing outstanding, 1 = memory access in flight, 2 = answer cycle
    int          m_ph;
    logic        m_dm, m_we;
    logic [31:0] m_addr, m_wdata, m_ifrd, m_dmrd;
    int          m_streak;

    task automatic model_reset();
        m_ph = 0; m_dm = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        m_ifrd = 0; m_dmrd = 0; m_streak = 0;
    endtask

    task automatic model_step();
        if (m_ph == 0) begin
            if (dm_req && !(if_req && m_streak == MAX_RUN)) begin
                m_dm = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                m_streak = (m_streak < MAX_RUN) ? m_streak + 1 : MAX_RUN;
                m_ph = 1;
            end else if (if_req) begin
                m_dm = 0; m_we = 0; m_addr = if_addr; m_wdata = 0;
                m_streak = 0;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (mem_ready) begin
                if (!m_dm)     m_ifrd = mem_rdata;
                else if (!m_we) m_dmrd = mem_rdata;
                m_ph = 2;
            end
        end else begin
            m_ph = 0;
        end
    endtask

    task automatic check_model();
        chk("rnd mem_en",    {31'd0, mem_en},  {31'd0, m_ph == 1});
        chk("rnd mem_we",    {31'd0, mem_we},  {31'd0, (m_ph == 1) && m_dm && m_we});
        chk("rnd mem_addr",  mem_addr,  m_addr);
        chk("rnd mem_wdata", mem_wdata, m_wdata);
        chk("rnd if_ack",    {31'd0, if_ack},  {31'd0, (m_ph == 2) && !m_dm});
        chk("rnd dm_ack",    {31'd0, dm_ack},  {31'd0, (m_ph == 2) && m_dm});
        chk("rnd busy",      {31'd0, busy},    {31'd0, m_ph != 0});
        chk("rnd if_rdata",  if_rdata,  m_ifrd);
        chk("rnd dm_rdata",  dm_rdata,  m_dmrd);
    endtask

    initial begin
        vec_t vecs[15];
        int   grants[$];
        int   ng;
        bit   seen_if;

        vecs[0]  = mk(1,32'h3000,0,0,0,0,1,32'h8C010004,   0,0,0,0,0,0,0,0,0);
        vecs[1]  = mk(1,32'h3000,0,0,0,0,1,32'h8C010004,   1,0,32'h3000,0,0,0,1,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0,0,                     0,0,32'h3000,0,1,0,1,32'h8C010004,0);
        vecs[3]  = mk(0,0,1,1,32'h10,32'hDEADBEEF,0,0,     0,0,32'h3000,0,0,0,0,32'h8C010004,0);
        vecs[4]  = mk(0,0,1,1,32'h10,32'hDEADBEEF,0,0,     1,1,32'h10,32'hDEADBEEF,0,0,1,32'h8C010004,0);
        vecs[5]  = mk(0,0,1,1,32'h10,32'hDEADBEEF,0,0,     1,1,32'h10,32'hDEADBEEF,0,0,1,32'h8C010004,0);
        vecs[6]  = mk(0,0,1,1,32'h10,32'hDEADBEEF,1,32'h12345678, 1,1,32'h10,32'hDEADBEEF,0,0,1,32'h8C010004,0);
        vecs[7]  = mk(0,0,0,0,0,0,0,0,                     0,0,32'h10,32'hDEADBEEF,0,1,1,32'h8C010004,0);
        vecs[8]  = mk(1,32'h400,1,0,32'h20,0,1,32'hA5A50001, 0,0,32'h10,32'hDEADBEEF,0,0,0,32'h8C010004,0);
        vecs[9]  = mk(1,32'h400,1,0,32'h20,0,1,32'hA5A50001, 1,0,32'h20,0,0,0,1,32'h8C010004,0);
        vecs[10] = mk(1,32'h400,0,0,0,0,1,32'h0BADF00D,    0,0,32'h20,0,0,1,1,32'h8C010004,32'hA5A50001);
        vecs[11] = mk(1,32'h400,0,0,0,0,1,32'h0BADF00D,    0,0,32'h20,0,0,0,0,32'h8C010004,32'hA5A50001);
        vecs[12] = mk(1,32'h400,0,0,0,0,1,32'h0BADF00D,    1,0,32'h400,0,0,0,1,32'h8C010004,32'hA5A50001);
        vecs[13] = mk(0,0,0,0,0,0,0,0,                     0,0,32'h400,0,1,0,1,32'h0BADF00D,32'hA5A50001);
        vecs[14] = mk(0,0,0,0,0,0,0,0,                     0,0,32'h400,0,0,0,0,32'h0BADF00D,32'hA5A50001);

        // Reset state, held in reset
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
        #3;
        chk("rst mem_en", {31'd0, mem_en}, 0);
        chk("rst busy",   {31'd0, busy}, 0);
        chk("rst acks",   {30'd0, if_ack, dm_ack}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst rdata",  if_rdata | dm_rdata | mem_wdata, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table: each row checks this cycle's outputs, then drives this cycle's inputs
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d mem_en", i),    {31'd0, mem_en},  {31'd0, vecs[i].en});
            chk($sformatf("v%0d mem_we", i),    {31'd0, mem_we},  {31'd0, vecs[i].we});
            chk($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
            chk($sformatf("v%0d if_ack", i),    {31'd0, if_ack},  {31'd0, vecs[i].ifack});
            chk($sformatf("v%0d dm_ack", i),    {31'd0, dm_ack},  {31'd0, vecs[i].dmack});
            chk($sformatf("v%0d busy", i),      {31'd0, busy},    {31'd0, vecs[i].bsy});
            chk($sformatf("v%0d if_rdata", i),  if_rdata,  vecs[i].ifrd);
            chk($sformatf("v%0d dm_rdata", i),  dm_rdata,  vecs[i].dmrd);
            set_in(vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].dwe, vecs[i].dma,
                   vecs[i].dwd, vecs[i].rdy, vecs[i].rd);
        end

        // Starvation: both requesters always pending, expect DDDDI DDDDI
        do_reset();
        set_in(1, 32'h9000, 1, 0, 32'h40, 0, 1, 32'h1);
        ng = 0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            @(negedge clk);
            if (mem_en && (state_is_new_access())) begin
                grants.push_back(mem_addr == 32'h9000 ? 1 : 0);
                ng++;
            end
            if_req = !if_ack;
            dm_req = !dm_ack;
        end
        chk("starve grant count", ng, 10);
        for (int i = 0; i < grants.size(); i++)
            chk($sformatf("starve grant%0d is_fetch", i), grants[i], (i % 5 == 4) ? 1 : 0);

        // Reset mid-wait on a store, then a pending fetch is served normally
        do_reset();
        set_in(0, 0, 1, 1, 32'h80, 32'h1, 0, 0);
        @(negedge clk);
        chk("midrst pre mem_en", {31'd0, mem_en}, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst mem_en", {31'd0, mem_en}, 0);
        chk("midrst busy",   {31'd0, busy}, 0);
        chk("midrst mem_we", {31'd0, mem_we}, 0);
        @(negedge clk);
        chk("midrst no dm_ack", {31'd0, dm_ack}, 0);
        set_in(1, 32'h5000, 0, 0, 0, 0, 1, 32'hCAFE0001);
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst mem_en",   {31'd0, mem_en}, 1);
        chk("post-rst mem_addr", mem_addr, 32'h5000);
        @(negedge clk);
        chk("post-rst if_ack",   {31'd0, if_ack}, 1);
        chk("post-rst dm_ack",   {31'd0, dm_ack}, 0);
        chk("post-rst if_rdata", if_rdata, 32'hCAFE0001);
        if_req = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        seen_if = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check_model();
            if (if_req && m_ph == 2 && !m_dm) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_req && m_ph == 2 && m_dm) dm_req = 1'b0;
            else if (!dm_req && $urandom_range(0, 1) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // A new access is visible as mem_en rising from the previous sampled cycle
    logic prev_en = 1'b0;
    always @(negedge clk) prev_en <= mem_en;
    function automatic bit state_is_new_access();
        return !prev_en;
    endfunction

endmodule

`default_nettype wire
